branch_resolver: RTL and testbench

Execute-stage consumer of the branch comparator's `breq`/`brlt` flags. It drives the comparator's signed/unsigned select and decides whether a branch or jump is taken. It also computes the target, issues a registered PC redirect to fetch under a valid/ready handshake, and squashes wrong-path instructions with a timed flush window. It also keeps running branch/taken statistics.

---
 rtl/branch_resolver.sv | 231 +++++++++++++++++++++++
 tb/tb_branch_resolver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Execute-stage branch/jump resolution. Consumes the comparator's breq/brlt
// flags, drives the comparator's unsigned select, decides taken/not-taken,
// computes the target and issues a registered PC redirect to fetch under a
// valid/ready handshake. Younger instructions are squashed via flush_o for
// the redirect cycles plus a fixed post-handshake window. Running counts of
// legal conditional branches and taken conditional branches are kept.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   valid_i                execute-stage instruction valid (ignored while busy)
//   opcode_i, funct3_i     instruction decode fields
//   pc_i, imm_i, rs1_i     PC, sign-extended immediate, rs1 data (JALR)
//   breq_i, brlt_i         comparator flags
//   brun_o                 comparator unsigned select (combinational)
//   redirect_valid_o/pc_o  redirect request to fetch
//   redirect_ready_i       fetch accepts redirect
//   flush_o                squash younger instructions
//   busy_o                 block is not idle
//   misalign_o             one-cycle pulse on a misaligned taken target
//   branch_cnt_o           accepted legal B-type count
//   taken_cnt_o            taken B-type count
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [AWIDTH-1:0]    pc_i,
    input  logic [DWIDTH-1:0]    imm_i,
    input  logic [DWIDTH-1:0]    rs1_i,
    input  logic                 breq_i,
    input  logic                 brlt_i,
    output logic                 brun_o,
    output logic                 redirect_valid_o,
    output logic [AWIDTH-1:0]    redirect_pc_o,
    input  logic                 redirect_ready_i,
    output logic                 flush_o,
    output logic                 busy_o,
    output logic                 misalign_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] taken_cnt_o
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter must be able to hold FLUSH_CYCLES itself.
    localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // Operand sizing into the PC domain (target math is modulo 2^AWIDTH)
    // -------------------------------------------------------------------------
    logic [AWIDTH-1:0] imm_a;
    logic [AWIDTH-1:0] rs1_a;

    generate
        if (DWIDTH >= AWIDTH) begin : g_trunc
            assign imm_a = imm_i[AWIDTH-1:0];
            assign rs1_a = rs1_i[AWIDTH-1:0];
        end else begin : g_ext
            assign imm_a = {{(AWIDTH-DWIDTH){imm_i[DWIDTH-1]}}, imm_i};
            assign rs1_a = {{(AWIDTH-DWIDTH){1'b0}}, rs1_i};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Combinational decode: taken decision and target
    // -------------------------------------------------------------------------
    logic              is_branch;
    logic              br_legal;
    logic              br_cond;
    logic              taken;
    logic [AWIDTH-1:0] pc_rel;
    logic [AWIDTH-1:0] reg_rel;
    logic [AWIDTH-1:0] target;

    assign is_branch = (opcode_i == OP_BRANCH);

    // funct3[1] distinguishes BLTU/BGEU from BLT/BGE.
    assign brun_o = is_branch & funct3_i[1];

    always_comb begin
        br_legal = 1'b1;
        br_cond  = 1'b0;
        case (funct3_i)
            3'b000:          br_cond = breq_i;
            3'b001:          br_cond = ~breq_i;
            3'b100, 3'b110:  br_cond = brlt_i;
            3'b101, 3'b111:  br_cond = ~brlt_i;
            default: begin
                br_legal = 1'b0;
                br_cond  = 1'b0;
            end
        endcase
    end

    assign pc_rel  = pc_i + imm_a;
    assign reg_rel = rs1_a + imm_a;

    always_comb begin
        taken  = 1'b0;
        target = pc_rel;
        case (opcode_i)
            OP_BRANCH: taken = br_legal & br_cond;
            OP_JAL:    taken = 1'b1;
            OP_JALR: begin
                taken  = 1'b1;
                target = {reg_rel[AWIDTH-1:1], 1'b0};
            end
            default:   taken = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    state_e            state_q;
    logic [FCW-1:0]    fcnt_q;
    logic              rvalid_q;
    logic [AWIDTH-1:0] rpc_q;
    logic              flush_q;
    logic              misalign_q;
    logic              accept;

    assign accept = valid_i & (state_q == S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            fcnt_q     <= '0;
            rvalid_q   <= 1'b0;
            rpc_q      <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            // Misalign is a single-cycle pulse unless re-armed this cycle.
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && taken) begin
                        if (target[1]) begin
                            // Misaligned target: report only, no redirect.
                            misalign_q <= 1'b1;
                        end else begin
                            state_q  <= S_REDIRECT;
                            rpc_q    <= target;
                            rvalid_q <= 1'b1;
                            flush_q  <= 1'b1;
                        end
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        rvalid_q <= 1'b0;
                        fcnt_q   <= FCW'(FLUSH_CYCLES);
                        state_q  <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Leaving on the 1->0 step gives exactly FLUSH_CYCLES cycles here.
                    fcnt_q <= fcnt_q - FCW'(1);
                    if (fcnt_q <= FCW'(1)) begin
                        fcnt_q  <= '0;
                        flush_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    rvalid_q <= 1'b0;
                    flush_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters (wrap naturally at 2^CNT_WIDTH)
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] taken_cnt_q,  taken_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (accept && is_branch && br_legal) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            if (br_cond) begin
                taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign redirect_valid_o = rvalid_q;
    assign redirect_pc_o    = rpc_q;
    assign flush_o          = flush_q;
    assign busy_o           = (state_q != S_IDLE);
    assign misalign_o       = misalign_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign taken_cnt_o      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int FC = 2;
    localparam int CW = 4;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i;
    logic [6:0]    opcode_i;
    logic [2:0]    funct3_i;
    logic [AW-1:0] pc_i;
    logic [DW-1:0] imm_i;
    logic [DW-1:0] rs1_i;
    logic          breq_i;
    logic          brlt_i;
    logic          brun_o;
    logic          redirect_valid_o;
    logic [AW-1:0] redirect_pc_o;
    logic          redirect_ready_i;
    logic          flush_o;
    logic          busy_o;
    logic          misalign_o;
    logic [CW-1:0] branch_cnt_o;
    logic [CW-1:0] taken_cnt_o;

    int total = 0;
    int bad   = 0;

    branch_resolver #(
        .DWIDTH(DW), .AWIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .pc_i(pc_i),
        .imm_i(imm_i), .rs1_i(rs1_i), .breq_i(breq_i), .brlt_i(brlt_i),
        .brun_o(brun_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
        .flush_o(flush_o), .busy_o(busy_o), .misalign_o(misalign_o),
        .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next active edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".rv"},    64'(redirect_valid_o), 64'd0);
        chk({tag, ".flush"}, 64'(flush_o),          64'd0);
        chk({tag, ".busy"},  64'(busy_o),           64'd0);
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; opcode_i = OP_ALU; funct3_i = 3'b000;
        pc_i = '0; imm_i = '0; rs1_i = '0; breq_i = 1'b0; brlt_i = 1'b0;
        redirect_ready_i = 1'b1;

        // ---- reset state ----
        #2;
        chk("rst.rv",    64'(redirect_valid_o), 64'd0);
        chk("rst.rpc",   64'(redirect_pc_o),    64'd0);
        chk("rst.flush", 64'(flush_o),          64'd0);
        chk("rst.mis",   64'(misalign_o),       64'd0);
        chk("rst.bcnt",  64'(branch_cnt_o),     64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rst.busy", 64'(busy_o), 64'd0);

        // ---- BEQ taken, ready high ----
        valid_i = 1'b1; opcode_i = OP_B; funct3_i = 3'b000; breq_i = 1'b1;
        pc_i = 32'h100; imm_i = 32'h20;
        #1 chk("beq.brun", 64'(brun_o), 64'd0);
        tick();
        valid_i = 1'b0;
        chk("beq.rv",    64'(redirect_valid_o), 64'd1);
        chk("beq.rpc",   64'(redirect_pc_o),    64'h120);
        chk("beq.flush", 64'(flush_o),          64'd1);
        chk("beq.busy",  64'(busy_o),           64'd1);
        chk("beq.bcnt",  64'(branch_cnt_o),     64'd1);
        chk("beq.tcnt",  64'(taken_cnt_o),      64'd1);
        tick();
        chk("beq.f1.rv",    64'(redirect_valid_o), 64'd0);
        chk("beq.f1.flush", 64'(flush_o),          64'd1);
        tick();
        chk("beq.f2.flush", 64'(flush_o), 64'd1);
        chk("beq.f2.busy",  64'(busy_o),  64'd1);
        tick();
        idle_chk("beq.end");

        // ---- BLTU not taken ----
        valid_i = 1'b1; funct3_i = 3'b110; brlt_i = 1'b0; breq_i = 1'b0;
        #1 chk("bltu.brun", 64'(brun_o), 64'd1);
        tick();
        valid_i = 1'b0;
        idle_chk("bltu");
        chk("bltu.bcnt", 64'(branch_cnt_o), 64'd2);
        chk("bltu.tcnt", 64'(taken_cnt_o),  64'd1);

        // ---- illegal funct3 010 and a non-branch opcode: no effect ----
        valid_i = 1'b1; funct3_i = 3'b010; breq_i = 1'b1; brlt_i = 1'b1;
        tick();
        opcode_i = OP_ALU; funct3_i = 3'b110;
        #1 chk("alu.brun", 64'(brun_o), 64'd0);
        tick();
        valid_i = 1'b0;
        idle_chk("ill");
        chk("ill.bcnt", 64'(branch_cnt_o), 64'd2);
        chk("ill.tcnt", 64'(taken_cnt_o),  64'd1);

        // ---- BGE taken (signed compare, brlt=0) ----
        valid_i = 1'b1; opcode_i = OP_B; funct3_i = 3'b101; brlt_i = 1'b0;
        pc_i = 32'h200; imm_i = 32'h10;
        #1 chk("bge.brun", 64'(brun_o), 64'd0);
        tick();
        valid_i = 1'b0;
        chk("bge.rpc",  64'(redirect_pc_o), 64'h210);
        chk("bge.tcnt", 64'(taken_cnt_o),   64'd2);
        tick(); tick(); tick();
        idle_chk("bge.end");

        // ---- JAL with fetch stalled for 5 cycles ----
        redirect_ready_i = 1'b0;
        valid_i = 1'b1; opcode_i = OP_JAL; pc_i = 32'h40; imm_i = 32'hFFFF_FFF8;
        tick();
        opcode_i = OP_B; funct3_i = 3'b000; breq_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall.rv",  64'(redirect_valid_o), 64'd1);
            chk("stall.rpc", 64'(redirect_pc_o),    64'h38);
            valid_i = (i % 2 == 0);
            tick();
        end
        valid_i = 1'b0;
        redirect_ready_i = 1'b1;
        tick();
        chk("stall.hs.rv",    64'(redirect_valid_o), 64'd0);
        chk("stall.hs.flush", 64'(flush_o),          64'd1);
        chk("stall.bcnt",     64'(branch_cnt_o),     64'd3);
        chk("stall.tcnt",     64'(taken_cnt_o),      64'd2);
        tick();
        chk("stall.f2.flush", 64'(flush_o), 64'd1);
        tick();
        idle_chk("stall.end");

        // ---- JALR misaligned, back-to-back ----
        valid_i = 1'b1; opcode_i = OP_JALR; rs1_i = 32'h1001; imm_i = 32'h1;
        tick();
        chk("mis1", 64'(misalign_o), 64'd1);
        idle_chk("mis1");
        tick();
        valid_i = 1'b0;
        chk("mis2", 64'(misalign_o), 64'd1);
        tick();
        chk("mis.off", 64'(misalign_o), 64'd0);
        idle_chk("mis.end");

        // ---- asynchronous reset mid-REDIRECT ----
        redirect_ready_i = 1'b0;
        valid_i = 1'b1; opcode_i = OP_JAL; pc_i = 32'h80; imm_i = 32'h4;
        tick();
        valid_i = 1'b0; opcode_i = OP_B; funct3_i = 3'b111;
        chk("ar.pre.rv", 64'(redirect_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar.rv",    64'(redirect_valid_o), 64'd0);
        chk("ar.rpc",   64'(redirect_pc_o),    64'd0);
        chk("ar.flush", 64'(flush_o),          64'd0);
        chk("ar.bcnt",  64'(branch_cnt_o),     64'd0);
        chk("ar.tcnt",  64'(taken_cnt_o),      64'd0);
        chk("ar.brun",  64'(brun_o),           64'd1);
        tick();
        rst_ni = 1'b1;
        redirect_ready_i = 1'b1;
        #1 chk("ar.busy", 64'(busy_o), 64'd0);

        // ---- counter wrap (CW=4) and PC wrap ----
        opcode_i = OP_B; funct3_i = 3'b000; breq_i = 1'b1;
        pc_i = 32'hFFFF_FFFC; imm_i = 32'h8;
        for (int i = 0; i < 17; i++) begin
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            if (i == 0) chk("wrap.rpc", 64'(redirect_pc_o), 64'h4);
            tick(); tick(); tick();
        end
        chk("wrap.bcnt", 64'(branch_cnt_o), 64'd1);
        chk("wrap.tcnt", 64'(taken_cnt_o),  64'd1);
        idle_chk("wrap.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
